// File: rtl/seq_udiv16by8.sv
// Restoring unsigned divider, one quotient bit per clock: result after DW_N edges, divide-by-zero right after accept.
// Accepts only in IDLE; the result holds in DONE until out_ready, so the period is DW_N+2 cycles back-to-back.
module seq_udiv16by8 #(
  parameter int DW_N = 16,
  parameter int DW_D = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (DW_N > 1) ? $clog2(DW_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW_N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [DW_N-1:0] q_q, q_d;
  logic [DW_D-1:0] r_q, r_d;
  logic [DW_D-1:0] d_q;
  logic [CW-1:0]   cnt_q;
  logic [DW_N-1:0] quot_q;
  logic [DW_D-1:0] rem_q;
  logic            dbz_q;
  logic [DW_D:0]   t;
  logic            ge;

  // The restored remainder is always below the divisor, so R fits in DW_D bits;
  // only the trial value T needs the extra bit for the compare.
  always_comb begin
    t   = {r_q, q_q[DW_N-1]};
    ge  = (t >= {1'b0, d_q});
    r_d = ge ? (t[DW_D-1:0] - d_q) : t[DW_D-1:0];
    q_d = (q_q << 1) | DW_N'(ge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              q_q     <= dividend;
              r_q     <= '0;
              d_q     <= divisor;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend[DW_D-1:0];
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_udiv16by8.sv
// Randomized and directed checks of seq_udiv16by8 against a plain-arithmetic division model.
module tb_seq_udiv16by8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_udiv16by8 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic z);
    int ai, bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = 16'(ai / bi);
      r = 8'(ai % bi);
      z = 1'b0;
    end
  endfunction

  // Present a request and wait (bounded) for the accepting edge; acc is the cycle stamp of that edge.
  task automatic send(input logic [15:0] a, input logic [7:0] b, output int acc, output bit ok);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        at = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (quotient !== 16'd0) begin bad++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One full request with value and latency checks; latency 16 edges for normal, 0 edges (next cycle) for divide-by-zero.
  task automatic run_one(input string name, input logic [15:0] a, input logic [7:0] b);
    int acc, at;
    bit ok;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    model(a, b, eq, er, ez);
    send(a, b, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_accept: got timeout want accept", name); return; end
    wait_out(at, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_out_valid: got timeout want result", name); return; end
    total++; if (quotient !== eq) begin bad++; $display("FAIL %s_quotient: %0d/%0d got %0d want %0d", name, a, b, quotient, eq); end
    total++; if (remainder !== er) begin bad++; $display("FAIL %s_remainder: %0d/%0d got %0d want %0d", name, a, b, remainder, er); end
    total++; if (div_by_zero !== ez) begin bad++; $display("FAIL %s_dbz: got %b want %b", name, div_by_zero, ez); end
    total++; if ((at - acc) !== (ez ? 0 : 16)) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, at - acc, ez ? 0 : 16); end
    pop();
  endtask

  task automatic test_basic();
    run_one("basic", 16'd50000, 8'd7);
  endtask

  task automatic test_corners();
    logic [15:0] da [4] = '{16'd65535, 16'd65535, 16'd0, 16'd200};
    logic [7:0]  db [4] = '{8'd255, 8'd1, 8'd1, 8'd250};
    for (int i = 0; i < 4; i++) run_one("corner", da[i], db[i]);
  endtask

  task automatic test_div_zero();
    run_one("divzero", 16'd1000, 8'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_one("random", 16'($urandom), (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
  endtask

  task automatic test_backpressure();
    int acc, at;
    bit ok;
    send(16'd12345, 8'd77, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept: got timeout want accept"); return; end
    wait_out(at, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_out_valid: got timeout want result"); return; end
    dividend = 16'd999;
    divisor  = 8'd9;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd160 || remainder !== 8'd25) begin
        bad++;
        $display("FAIL bp_hold: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=160 r=25",
                 out_valid, in_ready, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept: got in_ready=%b want 0", in_ready); end
    wait_out(at, ok);
    total++; if (!ok || quotient !== 16'd111 || remainder !== 8'd0 || (at - acc) !== 16) begin
      bad++; $display("FAIL bp_next_result: got q=%0d r=%0d lat=%0d want q=111 r=0 lat=16", quotient, remainder, at - acc);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    bit seen;
    send(16'd40000, 8'd3, acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_accept: got timeout want accept"); return; end
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL rstmid_clear: got v=%b q=%0d r=%0d z=%b want all 0", out_valid, quotient, remainder, div_by_zero);
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rstmid_no_result: got out_valid=1 want 0"); end
    run_one("rstmid_reissue", 16'd40000, 8'd3);
  endtask

  task automatic test_back_to_back();
    int acc, prev_acc, at;
    bit ok;
    logic [7:0]  x, y;
    logic [15:0] p;
    out_ready = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 150; i++) begin
      case (i)
        0: begin x = 8'd255; y = 8'd255; end
        1: begin x = 8'd1;   y = 8'd1;   end
        2: begin x = 8'd1;   y = 8'd255; end
        3: begin x = 8'd255; y = 8'd1;   end
        default: begin x = 8'($urandom_range(1, 255)); y = 8'($urandom_range(1, 255)); end
      endcase
      p = 16'(int'(x) * int'(y));
      send(p, y, acc, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_accept: got timeout want accept"); break; end
      if (prev_acc >= 0) begin
        total++; if ((acc - prev_acc) !== 18) begin bad++; $display("FAIL b2b_period: got %0d want 18", acc - prev_acc); end
      end
      prev_acc = acc;
      wait_out(at, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_out_valid: got timeout want result"); break; end
      total++; if (quotient !== {8'd0, x} || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
        bad++; $display("FAIL b2b_inverse: %0d/%0d got q=%0d r=%0d want q=%0d r=0", p, y, quotient, remainder, x);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
